// File: rtl/ghost_position_keeper.sv
// Authoritative ghost position: once per move period samples the steering proposal, checks bounds/grid/walls/direction, commits or rejects.
// Optional x-axis tunnel wrap enabled by defining GHOST_TUNNEL_WRAP_EN.

`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 24
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module ghost_position_keeper #(
    parameter int         TILE_SIZE   = 20,
    parameter int         MOVE_PERIOD = 5000000,
    parameter int         START_X     = 20,
    parameter int         START_Y     = 320,
    parameter logic [1:0] START_DIR   = `DIR_RIGHT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     freeze,
    input  logic [$clog2(`WIDTH)-1:0]                next_x,
    input  logic [$clog2(`HEIGHT)-1:0]               next_y,
    input  logic [1:0]                               ghost_direction,
    input  logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0]   tilemap_walls,
    output logic [$clog2(`WIDTH)-1:0]                x,
    output logic [$clog2(`HEIGHT)-1:0]               y,
    output logic [1:0]                               direction,
    output logic                                     moved,
    output logic                                     blocked
);

    localparam int XW   = $clog2(`WIDTH);
    localparam int YW   = $clog2(`HEIGHT);
    localparam int COLS = `TILE_COL_NUM;
    localparam int ROWS = `TILE_ROW_NUM;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int IW   = $clog2(COLS * ROWS);
    localparam int KW   = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

    localparam logic [XW:0] X_MAX = (XW+1)'(`WIDTH - TILE_SIZE);
    localparam logic [YW:0] Y_MAX = (YW+1)'(`HEIGHT - TILE_SIZE);
`ifdef GHOST_TUNNEL_WRAP_EN
    localparam logic [XW:0] X_WRAP_R = (XW+1)'(`WIDTH);
    localparam logic [XW:0] X_WRAP_L = (XW+1)'((1 << XW) - TILE_SIZE);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CHECK,
        S_COMMIT,
        S_REJECT
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d, px_q, px_d, tx_q, tx_d;
    logic [YW-1:0]   y_q, y_d, py_q, py_d, ty_q, ty_d;
    logic [1:0]      dir_q, dir_d, pd_q, pd_d;
    logic [CW-1:0]   col_q, col_d, tcol_q, tcol_d;
    logic [RW-1:0]   row_q, row_d, trow_q, trow_d;
    logic            moved_q, moved_d, blocked_q, blocked_d;

    logic [XW:0]     xe, pxe, tsx;
    logic [YW:0]     ye, pye, tsy;
    logic            same_x, same_y, geom_ok, dir_ok, wall_hit, legal;
    logic [XW-1:0]   tgt_x;
    logic [YW-1:0]   tgt_y;
    logic [CW-1:0]   tgt_col;
    logic [RW-1:0]   tgt_row;
    logic [IW-1:0]   wall_idx;

    assign xe     = {1'b0, x_q};
    assign pxe    = {1'b0, px_q};
    assign tsx    = (XW+1)'(TILE_SIZE);
    assign ye     = {1'b0, y_q};
    assign pye    = {1'b0, py_q};
    assign tsy    = (YW+1)'(TILE_SIZE);
    assign same_x = (px_q == x_q);
    assign same_y = (py_q == y_q);

    // Tile indices move by +-1 (or wrap) alongside the pixel position, so no divider is needed.
    always_comb begin
        geom_ok = 1'b0;
        dir_ok  = 1'b0;
        tgt_x   = x_q;
        tgt_y   = y_q;
        tgt_col = col_q;
        tgt_row = row_q;
        if (same_x && same_y) begin
            geom_ok = 1'b1;
            dir_ok  = 1'b1;
        end else if (same_y && (pxe == xe + tsx) && (pxe <= X_MAX)) begin
            geom_ok = 1'b1;
            dir_ok  = (pd_q == `DIR_RIGHT);
            tgt_x   = px_q;
            tgt_col = col_q + CW'(1);
        end else if (same_y && (xe >= tsx) && (pxe + tsx == xe)) begin
            geom_ok = 1'b1;
            dir_ok  = (pd_q == `DIR_LEFT);
            tgt_x   = px_q;
            tgt_col = col_q - CW'(1);
        end
`ifdef GHOST_TUNNEL_WRAP_EN
        else if (same_y && (xe == X_MAX) && (pxe == X_WRAP_R)) begin
            geom_ok = 1'b1;
            dir_ok  = (pd_q == `DIR_RIGHT);
            tgt_x   = '0;
            tgt_col = '0;
        end else if (same_y && (x_q == '0) && (pxe == X_WRAP_L)) begin
            geom_ok = 1'b1;
            dir_ok  = (pd_q == `DIR_LEFT);
            tgt_x   = XW'(`WIDTH - TILE_SIZE);
            tgt_col = CW'(COLS - 1);
        end
`endif
        else if (same_x && (pye == ye + tsy) && (pye <= Y_MAX)) begin
            geom_ok = 1'b1;
            dir_ok  = (pd_q == `DIR_DOWN);
            tgt_y   = py_q;
            tgt_row = row_q + RW'(1);
        end else if (same_x && (ye >= tsy) && (pye + tsy == ye)) begin
            geom_ok = 1'b1;
            dir_ok  = (pd_q == `DIR_UP);
            tgt_y   = py_q;
            tgt_row = row_q - RW'(1);
        end
    end

    assign wall_idx = IW'(tgt_row) * IW'(COLS) + IW'(tgt_col);
    assign wall_hit = tilemap_walls[wall_idx];
    assign legal    = geom_ok & dir_ok & ~wall_hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        col_d     = col_q;
        row_d     = row_q;
        px_d      = px_q;
        py_d      = py_q;
        pd_d      = pd_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        tcol_d    = tcol_q;
        trow_d    = trow_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;

        // Counter keeps running through the move pipeline so attempts stay exactly one period apart.
        if (!freeze) begin
            cnt_d = (cnt_q == KW'(MOVE_PERIOD - 1)) ? '0 : cnt_q + KW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!freeze && (cnt_q == KW'(MOVE_PERIOD - 1))) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                px_d    = next_x;
                py_d    = next_y;
                pd_d    = ghost_direction;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                tx_d    = tgt_x;
                ty_d    = tgt_y;
                tcol_d  = tgt_col;
                trow_d  = tgt_row;
                state_d = legal ? S_COMMIT : S_REJECT;
            end
            S_COMMIT: begin
                x_d     = tx_q;
                y_d     = ty_q;
                col_d   = tcol_q;
                row_d   = trow_q;
                dir_d   = pd_q;
                moved_d = 1'b1;
                state_d = S_IDLE;
            end
            S_REJECT: begin
                blocked_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            x_q       <= XW'(START_X);
            y_q       <= YW'(START_Y);
            dir_q     <= START_DIR;
            col_q     <= CW'(START_X / TILE_SIZE);
            row_q     <= RW'(START_Y / TILE_SIZE);
            px_q      <= '0;
            py_q      <= '0;
            pd_q      <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            tcol_q    <= '0;
            trow_q    <= '0;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            col_q     <= col_d;
            row_q     <= row_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pd_q      <= pd_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            tcol_q    <= tcol_d;
            trow_q    <= trow_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign direction = dir_q;
    assign moved     = moved_q;
    assign blocked   = blocked_q;

endmodule
